// File: rtl/imem_responder.sv
// imem_responder: dual-slot instruction memory responder for the fetch unit.
// Accepts one two-word read per cycle with no backpressure. Returns both words,
// their echoed PCs and per-slot fault flags after a fixed LATENCY pipeline.
// A single-word load port fills the array. Array contents survive reset.
module imem_responder #(
    parameter int          XLEN        = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] NOP_INSTR   = 32'hD503201F
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      imem_ren,
    input  logic [XLEN-1:0]           imem_addr0,
    input  logic [XLEN-1:0]           imem_addr1,
    input  logic                      flush,
    input  logic                      load_en,
    input  logic [XLEN-1:0]           load_addr,
    input  logic [31:0]               load_data,
    output logic                      imem_valid,
    output logic [XLEN-1:0]           imem_rdata0,
    output logic [XLEN-1:0]           imem_rdata1,
    output logic [1:0][XLEN-1:0]      imem_pc,
    output logic [1:0]                imem_fault,
    output logic [2:0]                inflight
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // One pipeline entry: everything the response needs, plus its valid bit.
    typedef struct packed {
        logic            valid;
        logic [1:0]      fault;
        logic [XLEN-1:0] data0;
        logic [XLEN-1:0] data1;
        logic [XLEN-1:0] pc0;
        logic [XLEN-1:0] pc1;
    } stage_t;

    logic [31:0] r_mem [DEPTH_WORDS];
    stage_t      r_pipe [LATENCY];

    stage_t      w_new;
    logic        w_fault0;
    logic        w_fault1;
    logic        w_load_ok;
    logic [2:0]  w_inflight;

    // An address is unusable if it is not word aligned or lies beyond the array.
    function automatic logic addr_faults(input logic [XLEN-1:0] a);
        return (a[1:0] != 2'b00) || (a[XLEN-1:AW+2] != '0);
    endfunction

    assign w_fault0  = addr_faults(imem_addr0);
    assign w_fault1  = addr_faults(imem_addr1);
    assign w_load_ok = load_en && !reset && !addr_faults(load_addr);

    // Build the stage-0 entry from the array as it stands before this edge's load.
    always_comb begin
        w_new       = '0;
        w_new.valid = 1'b1;
        w_new.fault = {w_fault1, w_fault0};
        w_new.pc0   = imem_addr0;
        w_new.pc1   = imem_addr1;
        w_new.data0 = w_fault0 ? XLEN'(NOP_INSTR) : XLEN'(r_mem[imem_addr0[AW+1:2]]);
        w_new.data1 = w_fault1 ? XLEN'(NOP_INSTR) : XLEN'(r_mem[imem_addr1[AW+1:2]]);
    end

    // Program-load write port; reads this cycle still see the old word.
    // NOTE: the array has no reset on purpose -- program contents must survive
    // a reset, and a resettable array would not map onto RAM.
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_mem[load_addr[AW+1:2]] <= load_data;
        end
    end

    // Response pipeline: shift entries, kill them on flush, hold data in bubbles.
    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // its predecessor's pre-edge value, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            // A request arriving alongside flush is new, so it is kept.
            if (imem_ren) begin
                r_pipe[0] <= w_new;
            end else begin
                r_pipe[0].valid <= 1'b0;
            end
            for (int i = 1; i < LATENCY; i++) begin
                if (r_pipe[i-1].valid && !flush) begin
                    r_pipe[i] <= r_pipe[i-1];
                end else begin
                    r_pipe[i].valid <= 1'b0;
                end
            end
        end
    end

    // Number of live entries anywhere in the pipeline.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_inflight = w_inflight + 3'(r_pipe[i].valid);
        end
    end

    assign imem_valid  = r_pipe[LATENCY-1].valid;
    assign imem_fault  = r_pipe[LATENCY-1].fault & {2{r_pipe[LATENCY-1].valid}};
    assign imem_rdata0 = r_pipe[LATENCY-1].data0;
    assign imem_rdata1 = r_pipe[LATENCY-1].data1;
    assign imem_pc[0]  = r_pipe[LATENCY-1].pc0;
    assign imem_pc[1]  = r_pipe[LATENCY-1].pc1;
    assign inflight    = w_inflight;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (LATENCY 1, 2, 3) share one stimulus.
// A vector table drives the LATENCY=1 read path; hand-written sequences cover
// collision, flush and reset corner cases on the deeper instances.
module tb_imem_responder;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk;
    logic        reset;
    logic        imem_ren;
    logic [31:0] imem_addr0;
    logic [31:0] imem_addr1;
    logic        flush;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    logic            v1, v2, v3;
    logic [31:0]     r0_1, r1_1, r0_2, r1_2, r0_3, r1_3;
    logic [1:0][31:0] pc_1, pc_2, pc_3;
    logic [1:0]      f_1, f_2, f_3;
    logic [2:0]      inf_1, inf_2, inf_3;

    int n_cmp  = 0;
    int n_fail = 0;

    imem_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .imem_ren(imem_ren), .imem_addr0(imem_addr0),
        .imem_addr1(imem_addr1), .flush(flush), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .imem_valid(v1), .imem_rdata0(r0_1), .imem_rdata1(r1_1),
        .imem_pc(pc_1), .imem_fault(f_1), .inflight(inf_1)
    );

    imem_responder #(.LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .imem_ren(imem_ren), .imem_addr0(imem_addr0),
        .imem_addr1(imem_addr1), .flush(flush), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .imem_valid(v2), .imem_rdata0(r0_2), .imem_rdata1(r1_2),
        .imem_pc(pc_2), .imem_fault(f_2), .inflight(inf_2)
    );

    imem_responder #(.LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset), .imem_ren(imem_ren), .imem_addr0(imem_addr0),
        .imem_addr1(imem_addr1), .flush(flush), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .imem_valid(v3), .imem_rdata0(r0_3), .imem_rdata1(r1_3),
        .imem_pc(pc_3), .imem_fault(f_3), .inflight(inf_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ren;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        ev;
        logic [31:0] er0;
        logic [31:0] er1;
        logic [31:0] ep0;
        logic [31:0] ep1;
        logic [1:0]  ef;
        logic [2:0]  einf;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic read_req(input logic [31:0] a0, input logic [31:0] a1);
        imem_ren   = 1'b1;
        imem_addr0 = a0;
        imem_addr1 = a1;
    endtask

    initial begin
        reset = 1'b1; imem_ren = 1'b0; imem_addr0 = '0; imem_addr1 = '0;
        flush = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;

        //          ren   a0            a1            ev    rdata0        rdata1        pc0           pc1           fault  inflight
        vecs[0] = '{1'b1, 32'h0,        32'h4,        1'b1, 32'h11111111, 32'h22222222, 32'h0,        32'h4,        2'b00, 3'd1};
        vecs[1] = '{1'b1, 32'h0,        32'h4,        1'b1, 32'h11111111, 32'h22222222, 32'h0,        32'h4,        2'b00, 3'd1};
        vecs[2] = '{1'b1, 32'h8,        32'hC,        1'b1, 32'h33333333, 32'h44444444, 32'h8,        32'hC,        2'b00, 3'd1};
        vecs[3] = '{1'b1, 32'h0,        32'h4,        1'b1, 32'h11111111, 32'h22222222, 32'h0,        32'h4,        2'b00, 3'd1};
        vecs[4] = '{1'b1, 32'hFFC,      32'h1000,     1'b1, 32'hDEADBEEF, NOP,          32'hFFC,      32'h1000,     2'b10, 3'd1};
        vecs[5] = '{1'b1, 32'h2,        32'h0,        1'b1, NOP,          32'h11111111, 32'h2,        32'h0,        2'b01, 3'd1};
        vecs[6] = '{1'b1, 32'h40000000, 32'hC,        1'b1, NOP,          32'h44444444, 32'h40000000, 32'hC,        2'b01, 3'd1};
        vecs[7] = '{1'b0, 32'h0,        32'h0,        1'b0, NOP,          32'h44444444, 32'h40000000, 32'hC,        2'b00, 3'd0};

        // Reset state.
        tick(); tick();
        check("rst_valid",    32'(v1), 32'h0);
        check("rst_rdata0",   r0_1, 32'h0);
        check("rst_rdata1",   r1_1, 32'h0);
        check("rst_pc0",      pc_1[0], 32'h0);
        check("rst_pc1",      pc_1[1], 32'h0);
        check("rst_fault",    32'(f_1), 32'h0);
        check("rst_inflight", 32'(inf_3), 32'h0);
        reset = 1'b0;
        tick();

        // Program load, including two loads that must be dropped.
        load_word(32'h0,   32'h11111111);
        load_word(32'h4,   32'h22222222);
        load_word(32'h8,   32'h33333333);
        load_word(32'hC,   32'h44444444);
        load_word(32'hFFC, 32'hDEADBEEF);
        load_word(32'h20,  32'h55555555);
        load_word(32'h24,  32'h66666666);
        load_word(32'h18,  32'h77777777);
        load_word(32'h1,    32'hBAD00001);
        load_word(32'h1000, 32'hBAD00002);

        // Table-driven read path on the LATENCY=1 instance.
        for (int i = 0; i < 8; i++) begin
            imem_ren   = vecs[i].ren;
            imem_addr0 = vecs[i].a0;
            imem_addr1 = vecs[i].a1;
            tick();
            check($sformatf("v%0d_valid", i),    32'(v1),    32'(vecs[i].ev));
            check($sformatf("v%0d_rdata0", i),   r0_1,       vecs[i].er0);
            check($sformatf("v%0d_rdata1", i),   r1_1,       vecs[i].er1);
            check($sformatf("v%0d_pc0", i),      pc_1[0],    vecs[i].ep0);
            check($sformatf("v%0d_pc1", i),      pc_1[1],    vecs[i].ep1);
            check($sformatf("v%0d_fault", i),    32'(f_1),   32'(vecs[i].ef));
            check($sformatf("v%0d_inflight", i), 32'(inf_1), 32'(vecs[i].einf));
        end

        // Flush on an empty pipeline changes nothing visible.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_empty_valid",    32'(v1), 32'h0);
        check("flush_empty_inflight", 32'(inf_1), 32'h0);
        check("flush_empty_hold",     r1_1, 32'h44444444);

        // Read-before-write collision on mem[2], then the new word next cycle.
        read_req(32'h8, 32'h4);
        load_en = 1'b1; load_addr = 32'h8; load_data = 32'hAAAA0000;
        tick();
        load_en = 1'b0;
        check("coll_old_word", r0_1, 32'h33333333);
        read_req(32'h8, 32'h4);
        tick();
        imem_ren = 1'b0;
        check("coll_new_word", r0_1, 32'hAAAA0000);
        repeat (4) tick();

        // Flush with a concurrent request on the LATENCY=3 instance.
        read_req(32'h0, 32'h4);
        tick();
        check("fl_inflight_1", 32'(inf_3), 32'd1);
        read_req(32'h8, 32'hC);
        tick();
        check("fl_inflight_2", 32'(inf_3), 32'd2);
        read_req(32'h20, 32'h24);
        flush = 1'b1;
        tick();
        imem_ren = 1'b0;
        flush    = 1'b0;
        check("fl_killed_valid", 32'(v3), 32'h0);
        check("fl_after_inflight", 32'(inf_3), 32'd1);
        tick();
        check("fl_gap_valid", 32'(v3), 32'h0);
        tick();
        check("fl_new_valid",  32'(v3), 32'h1);
        check("fl_new_pc0",    pc_3[0], 32'h20);
        check("fl_new_rdata0", r0_3, 32'h55555555);
        check("fl_new_rdata1", r1_3, 32'h66666666);
        tick();
        check("fl_drained_valid", 32'(v3), 32'h0);
        check("fl_drained_inflight", 32'(inf_3), 32'h0);
        repeat (2) tick();

        // Mid-operation reset on the LATENCY=2 instance.
        read_req(32'h0, 32'h4);
        tick();
        read_req(32'h8, 32'hC);
        tick();
        imem_ren = 1'b0;
        check("rr_pre_valid",    32'(v2), 32'h1);
        check("rr_pre_inflight", 32'(inf2_dummy(inf_2)), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("rr_async_valid",    32'(v2), 32'h0);
        check("rr_async_inflight", 32'(inf_2), 32'h0);
        // A load attempted under reset must not land.
        load_en = 1'b1; load_addr = 32'h18; load_data = 32'hBADBAD01;
        tick();
        load_en = 1'b0;
        reset   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rr_quiet%0d_valid", i), 32'(v2), 32'h0);
        end
        read_req(32'h0, 32'h18);
        tick();
        imem_ren = 1'b0;
        tick();
        check("rr_post_valid",  32'(v2), 32'h1);
        check("rr_post_rdata0", r0_2, 32'h11111111);
        check("rr_post_rdata1", r1_2, 32'h77777777);
        check("rr_post_fault",  32'(f_2), 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Identity pass-through so the pre-reset occupancy reads the same as others.
    function automatic logic [2:0] inf2_dummy(input logic [2:0] x);
        return x;
    endfunction

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder that serves the front-end fetch unit's dual-slot instruction read requests. Each cycle it can accept one request for two word addresses and returns both instruction words, their echoed PCs and a valid strobe after a fixed, parameterised latency. The default latency is one cycle, which matches fetch's two-cycle PC-to-decode path. A single-word program-load write port fills the array before or during simulation. The block sits between fetch and the testbench/program loader, replacing a plain memory model.

## Interface
- XLEN, 32, address/data width
- DEPTH_WORDS, 1024, array depth in 32-bit words (power of two)
- LATENCY, 1, request-to-response cycles (legal 1..4)
- NOP_INSTR, 32'hD503201F, word returned for faulting slots

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- imem_ren  in  1  read request strobe; accepted every cycle it is high (no backpressure)
- imem_addr0  in  XLEN  byte address, slot 0
- imem_addr1  in  XLEN  byte address, slot 1
- flush  in  1  discard all in-flight responses
- load_en  in  1  program-load write strobe
- load_addr  in  XLEN  byte address of load word
- load_data  in  32  load word
- imem_valid  out  1  response valid
- imem_rdata0  out  XLEN  instruction, slot 0
- imem_rdata1  out  XLEN  instruction, slot 1
- imem_pc  out  [1:0] x XLEN  echoed request addresses (imem_pc[0]=addr0, imem_pc[1]=addr1)
- imem_fault  out  2  per-slot fault flag, qualified by imem_valid
- inflight  out  3  number of accepted, not-yet-returned requests

## Operation
- Array: DEPTH_WORDS x 32. Word index is addr[log2(DEPTH_WORDS)+1:2]. The array is not cleared by reset; contents persist across reset.
- Request accept: when imem_ren=1, both slots are read in the accept cycle. The data, both addresses, both fault bits and a valid bit enter stage 0 of a LATENCY-deep shift pipeline. The last stage drives the outputs.
- Slot fault: a slot faults when addr[1:0]!=0 or when addr >= 4*DEPTH_WORDS. A faulting slot returns NOP_INSTR and sets its imem_fault bit. The other slot is unaffected.
- Load: when load_en=1, mem[load_addr word index] is written at the clock edge. Loads that are misaligned or out of range are dropped silently. Loads are ignored while reset is high.
- Read/write collision on the same word in the same cycle is read-before-write: the read returns the old word.
- Flush: clears the valid bit of every pipeline stage, including the stage currently driving outputs, at the next edge. A request presented in the same cycle as flush is accepted and survives the flush.
- Output hold: when the last stage is not valid, imem_valid=0 and imem_fault=0. imem_rdata0, imem_rdata1 and imem_pc keep their last values.
- inflight: count of valid bits across all pipeline stages, updated per edge. Range is 0..LATENCY.

## Timing
- Reset values: imem_valid=0, imem_rdata0/1=0, imem_pc[0]=imem_pc[1]=0, imem_fault=0, inflight=0, and every pipeline valid bit cleared. Reset takes effect asynchronously.
- Reset asserted mid-operation drops all in-flight responses immediately. The first response after deassertion comes only from requests accepted after reset is released.
- Latency: a request accepted at edge N has imem_valid=1 during the cycle after edge N+LATENCY-1. With LATENCY=1, this is the cycle immediately following the accept cycle.
- Throughput: one response per cycle. Back-to-back requests return back-to-back, in order.
- Load latency: a word written at edge N is visible to a read accepted in cycle N+1 or later.
- flush and imem_ren in the same cycle: the old entries are killed and the new entry is kept. inflight after the edge is 1.
- flush when the pipeline is empty: no effect.

## Test plan
- Load mem[0..3] = 0x11111111, 0x22222222, 0x33333333, 0x44444444. Present ren with addr0=0, addr1=4 at cycle N. Required at N+1: valid=1, rdata0=0x11111111, rdata1=0x22222222, pc={0,4}, fault=00.
- Present back-to-back requests at addresses 0, 8, 0 in consecutive cycles. Required: three consecutive valid responses in order, with pcs {0,4}, {8,12}, {0,4}. inflight stays at 1 for LATENCY=1.
- Present addr0=0xFFC, addr1=0x1000 (DEPTH_WORDS=1024). Required: rdata0=mem[1023], rdata1=0xD503201F, fault=10 (bit 1 set). A second request with addr0=0x2 must return rdata0=0xD503201F and fault[0]=1.
- With LATENCY=3: requests at cycles N and N+1, then flush together with a request (addr 0x20) at N+2. Required: no valid at N+3 or N+4; valid at N+5 with pc[0]=0x20. inflight reaches 2, then reads 1 after the flush edge.
- Load mem[2]=0xAAAA0000 and read addr0=8 in the same cycle. Required: the response returns the old word. A read of addr0=8 in the next cycle returns 0xAAAA0000.
- With LATENCY=2, two requests in flight: assert reset for one cycle. Required: imem_valid=0 and inflight=0 immediately, and no response appears after release. A subsequent read of addr0=0 returns the preloaded 0x11111111, because contents are retained.
